// File: rtl/vmx_cmd_dispatcher.sv
// VMX command front end: routes header+payload packets to NUM_CH channels with per-channel in-flight limits.
// Optional per-channel packet counters are enabled by defining VMX_DISPATCH_STATS_EN.
module vmx_cmd_dispatcher #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic                m_tlast,
  output logic [NUM_CH-1:0]   m_tvalid,
  input  logic [NUM_CH-1:0]   m_tready,
  input  logic [NUM_CH-1:0]   ch_done,
  output logic [NUM_CH-1:0]   ch_busy,
  output logic                idle,
  output logic                err_chan,
  output logic                err_len,
  input  logic                err_clr
`ifdef VMX_DISPATCH_STATS_EN
  ,
  output logic [NUM_CH*16-1:0] pkt_count
`endif
);

  typedef enum logic [2:0] {
    ST_HDR      = 3'd0,
    ST_CHECK    = 3'd1,
    ST_SEND_HDR = 3'd2,
    ST_FWD      = 3'd3,
    ST_DROP     = 3'd4
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   hdr;
  logic                hdr_last;
  logic [7:0]          cnt;
  logic [3:0]          outstanding [NUM_CH];

  logic [3:0]          sel;
  logic [7:0]          len;
  logic                ch_bad;
  logic                sel_ready;
  logic                sel_full;
  logic [NUM_CH-1:0]   sel_onehot;
  logic [NUM_CH-1:0]   disp;
  logic [NUM_CH-1:0]   retire;
  logic                last_beat;
  logic                hdr_tlast_out;

  assign sel           = hdr[27:24];
  assign len           = hdr[23:16];
  assign ch_bad        = ({1'b0, sel} >= 5'(NUM_CH));
  assign last_beat     = (cnt == (len - 8'd1));
  assign hdr_tlast_out = (len == 8'd0) | hdr_last;
  assign idle          = (state == ST_HDR) & ~(|ch_busy);

  // Per-channel decode of the selected channel, dispatch and completion events.
  always_comb begin
    sel_ready  = 1'b0;
    sel_full   = 1'b0;
    sel_onehot = '0;
    disp       = '0;
    retire     = '0;
    ch_busy    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_onehot[i] = (sel == 4'(i));
      sel_ready     = sel_ready | (sel_onehot[i] & m_tready[i]);
      sel_full      = sel_full  | (sel_onehot[i] & (outstanding[i] == 4'(MAX_OUT)));
      disp[i]       = (state == ST_SEND_HDR) & sel_onehot[i] & m_tready[i];
      retire[i]     = ch_done[i] & (outstanding[i] != 4'd0);
      ch_busy[i]    = (outstanding[i] != 4'd0);
    end
  end

  // Stream-side handshake and channel-side drive; FWD is a zero-latency pass-through.
  always_comb begin
    s_tready = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    m_tvalid = '0;
    case (state)
      ST_HDR:   s_tready = ~areset;
      ST_CHECK: s_tready = 1'b0;
      ST_SEND_HDR: begin
        m_tvalid = sel_onehot;
        m_tdata  = hdr;
        m_tlast  = hdr_tlast_out;
      end
      ST_FWD: begin
        s_tready = sel_ready;
        m_tvalid = s_tvalid ? sel_onehot : '0;
        m_tdata  = s_tvalid ? s_tdata : '0;
        m_tlast  = s_tvalid & (last_beat | s_tlast);
      end
      ST_DROP:  s_tready = 1'b1;
      default:  s_tready = 1'b0;
    endcase
  end

  // Packet FSM with sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= ST_HDR;
      hdr      <= '0;
      hdr_last <= 1'b0;
      cnt      <= 8'd0;
      err_chan <= 1'b0;
      err_len  <= 1'b0;
    end else begin
      case (state)
        ST_HDR: begin
          if (s_tvalid) begin
            hdr      <= s_tdata;
            hdr_last <= s_tlast;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (ch_bad) begin
            err_chan <= 1'b1;
            state    <= hdr_last ? ST_HDR : ST_DROP;
          end else if (!sel_full) begin
            state <= ST_SEND_HDR;
          end
        end
        ST_SEND_HDR: begin
          if (sel_ready) begin
            if (hdr_last && (len != 8'd0)) err_len <= 1'b1;
            cnt   <= 8'd0;
            state <= hdr_tlast_out ? ST_HDR : ST_FWD;
          end
        end
        ST_FWD: begin
          if (s_tvalid && sel_ready) begin
            cnt <= cnt + 8'd1;
            if (s_tlast) begin
              if (!last_beat) err_len <= 1'b1;
              state <= ST_HDR;
            end else if (last_beat) begin
              // Header length reached without tlast: close the packet downstream, discard the rest.
              err_len <= 1'b1;
              state   <= ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (s_tvalid && s_tlast) state <= ST_HDR;
        end
        default: state <= ST_HDR;
      endcase
      if (err_clr) begin
        err_chan <= 1'b0;
        err_len  <= 1'b0;
      end
    end
  end

  // In-flight counters; a dispatch and a completion in the same cycle cancel.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_CH; i++) outstanding[i] <= 4'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (disp[i] && !retire[i]) begin
          outstanding[i] <= outstanding[i] + 4'd1;
        end else if (retire[i] && !disp[i]) begin
          outstanding[i] <= outstanding[i] - 4'd1;
        end
      end
    end
  end

`ifdef VMX_DISPATCH_STATS_EN
  // Wrapping per-channel count of dispatched packets.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_count <= '0;
    end else if (err_clr) begin
      pkt_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (disp[i]) pkt_count[i*16 +: 16] <= pkt_count[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
